// File: rtl/mmu_l1_responder.sv
// L1 line-read responder: fetches a 32-byte line (8 words) or a single MMIO word
// from a word-wide backing memory and returns it on the 256-bit line bus.
module mmu_l1_responder #(
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         l1_mmu_req_read,
  input  logic [31:0]  l1_mmu_req_addr,
  output logic         mmu_l1_done,
  output logic [255:0] mmu_l1_read_data,
  output logic         mem_read,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rvalid
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StGap,
    StDrain
  } state_e;

  state_e         state_q;
  logic [31:0]    addr_q;
  logic [3:0]     beats_q;
  logic [3:0]     k_q;
  logic [31:0]    mem_addr_q;
  logic           done_q;
  logic [255:0]   rdata_q;

  logic           req_mmio;
  logic [31:0]    req_base;
  logic [3:0]     k_next;
  logic [31:0]    next_addr;

  assign req_mmio  = (l1_mmu_req_addr & MMIO_MASK) == MMIO_BASE;
  assign req_base  = req_mmio ? l1_mmu_req_addr : (l1_mmu_req_addr & ~32'h1F);
  assign k_next    = k_q + 4'd1;
  assign next_addr = addr_q + {27'd0, k_next[2:0], 2'b00};

  // The strobe is withheld in the cycle the requester drops, so an abort in
  // ISSUE never leaves a read outstanding.
  assign mem_read         = (state_q == StIssue) && l1_mmu_req_read;
  assign mem_addr         = mem_addr_q;
  assign mmu_l1_done      = done_q;
  assign mmu_l1_read_data = rdata_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beats_q    <= '0;
      k_q        <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (l1_mmu_req_read) begin
            addr_q     <= req_base;
            mem_addr_q <= req_base;
            beats_q    <= req_mmio ? 4'd1 : 4'd8;
            k_q        <= '0;
            rdata_q    <= '0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          state_q <= l1_mmu_req_read ? StWait : StIdle;
        end
        StWait: begin
          if (!l1_mmu_req_read) begin
            // A word arriving in the same cycle as the drop is simply discarded.
            state_q <= mem_rvalid ? StIdle : StDrain;
          end else if (mem_rvalid) begin
            rdata_q[{k_q[2:0], 5'd0} +: 32] <= mem_rdata;
            k_q <= k_next;
            if (k_next == beats_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              mem_addr_q <= next_addr;
              state_q    <= StIssue;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StGap;
        end
        StGap: begin
          state_q <= StIdle;
        end
        StDrain: begin
          if (mem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_l1_responder.sv
// Self-checking bench for mmu_l1_responder: table of line/MMIO fetches plus
// hand-written latency, abort, reset and back-to-back sequences.
module tb_mmu_l1_responder;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         l1_mmu_req_read;
  logic [31:0]  l1_mmu_req_addr;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;

  always #5 sys_clk = ~sys_clk;

  mmu_l1_responder dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .l1_mmu_req_read  (l1_mmu_req_read),
    .l1_mmu_req_addr  (l1_mmu_req_addr),
    .mmu_l1_done      (mmu_l1_done),
    .mmu_l1_read_data (mmu_l1_read_data),
    .mem_read         (mem_read),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .mem_rvalid       (mem_rvalid)
  );

  int checks = 0;
  int errors = 0;

  // Memory model and observation state.
  int           cyc;
  bit           pending;
  int           due;
  logic [31:0]  pend_addr;
  int           lat_tab[8];
  int           n_str;
  logic [31:0]  strobes[16];
  int           strobe_cyc[16];
  int           done_cnt;
  int           done_cyc;
  logic [255:0] done_data;
  bit           last_done = 1'b0;
  int           hold_err;
  int           multi_err;
  int           dbl_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          mmio;
    logic [31:0] base;
    int          done_at;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hFFFF_0004) ? 32'hDEAD_BEEF : a;
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] base, input bit mmio);
    logic [255:0] l;
    l = '0;
    if (mmio) begin
      l[31:0] = mem_word(base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        l[k*32 +: 32] = mem_word(base + 32'(4 * k));
      end
    end
    return l;
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic begin_fetch(input int lat);
    pending   = 1'b0;
    n_str     = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    hold_err  = 0;
    multi_err = 0;
    cyc       = 0;
    for (int i = 0; i < 8; i++) lat_tab[i] = lat;
    for (int i = 0; i < 16; i++) begin
      strobes[i]    = 'x;
      strobe_cyc[i] = -1;
    end
  endtask

  // One clock cycle: drive this cycle's inputs, answer memory, then observe.
  task automatic step(input bit req_v, input logic [31:0] addr_v, input bit spur,
                      input bit rst_v);
    @(negedge sys_clk);
    rst             = rst_v;
    l1_mmu_req_read = req_v;
    l1_mmu_req_addr = addr_v;
    mem_rvalid      = 1'b0;
    mem_rdata       = 32'h0BAD_0BAD;
    if (pending && due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_addr);
      pending    = 1'b0;
    end else if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_0000 | 32'(cyc);
    end
    #1;
    if (pending && mem_addr !== pend_addr) hold_err++;
    if (mem_read === 1'b1) begin
      if (pending) multi_err++;
      if (n_str < 16) begin
        strobes[n_str]    = mem_addr;
        strobe_cyc[n_str] = cyc;
      end
      due       = cyc + lat_tab[n_str % 8];
      pending   = 1'b1;
      pend_addr = mem_addr;
      n_str++;
    end
    if (mmu_l1_done === 1'b1) begin
      if (last_done) dbl_err++;
      done_cnt++;
      done_cyc  = cyc;
      done_data = mmu_l1_read_data;
    end
    last_done = (mmu_l1_done === 1'b1);
    cyc++;
  endtask

  initial begin
    int           nb;
    int           first_done;
    logic [31:0]  ea;

    vecs[0] = '{addr: 32'h0000_1234, lat: 1, mmio: 1'b0, base: 32'h0000_1220, done_at: 17};
    vecs[1] = '{addr: 32'hFFFF_0004, lat: 1, mmio: 1'b1, base: 32'hFFFF_0004, done_at: 3};
    vecs[2] = '{addr: 32'h8000_001F, lat: 2, mmio: 1'b0, base: 32'h8000_0000, done_at: 25};
    vecs[3] = '{addr: 32'hFFFE_FFFC, lat: 1, mmio: 1'b0, base: 32'hFFFE_FFE0, done_at: 17};
    vecs[4] = '{addr: 32'hFFFF_FFFF, lat: 3, mmio: 1'b1, base: 32'hFFFF_FFFF, done_at: 5};
    vecs[5] = '{addr: 32'h0000_0000, lat: 4, mmio: 1'b0, base: 32'h0000_0000, done_at: 41};

    rst             = 1'b1;
    l1_mmu_req_read = 1'b0;
    l1_mmu_req_addr = '0;
    mem_rvalid      = 1'b0;
    mem_rdata       = '0;

    // Reset state.
    begin_fetch(1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_int("reset_done", int'(mmu_l1_done), 0);
    chk_int("reset_mem_read", int'(mem_read), 0);
    chk_vec("reset_mem_addr", 256'(mem_addr), 256'h0);
    chk_vec("reset_read_data", mmu_l1_read_data, 256'h0);

    // Table of fetches; the request address is scrambled after cycle 0 to
    // confirm the latched address is used throughout.
    for (int i = 0; i < 6; i++) begin
      begin_fetch(vecs[i].lat);
      while (done_cnt == 0 && cyc < 300) begin
        step(1'b1, (cyc == 0) ? vecs[i].addr : (vecs[i].addr ^ 32'h5A5A_0060), 1'b0, 1'b0);
      end
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      nb = vecs[i].mmio ? 1 : 8;
      chk_int("vec_done_count", done_cnt, 1);
      chk_int("vec_done_cycle", done_cyc, vecs[i].done_at);
      chk_int("vec_strobe_count", n_str, nb);
      for (int k = 0; k < nb; k++) begin
        ea = vecs[i].mmio ? vecs[i].addr : (vecs[i].base + 32'(4 * k));
        chk_vec("vec_strobe_addr", 256'(strobes[k]), 256'(ea));
      end
      chk_vec("vec_line_data", done_data, exp_line(vecs[i].base, vecs[i].mmio));
      chk_vec("vec_data_holds", mmu_l1_read_data, exp_line(vecs[i].base, vecs[i].mmio));
      chk_int("vec_addr_stable", hold_err, 0);
      chk_int("vec_one_outstanding", multi_err, 0);
    end

    // Variable latency on beat 3 plus a spurious rvalid in the first ISSUE.
    begin_fetch(1);
    lat_tab[3] = 6;
    while (done_cnt == 0 && cyc < 300) begin
      step(1'b1, 32'h0000_1234, (cyc == 1), 1'b0);
    end
    chk_int("varlat_done_cycle", done_cyc, 22);
    chk_int("varlat_beat3_strobe", strobe_cyc[3], 7);
    chk_int("varlat_beat4_strobe", strobe_cyc[4], 14);
    chk_vec("varlat_beat3_addr", 256'(strobes[3]), 256'h122C);
    chk_int("varlat_addr_held", hold_err, 0);
    chk_vec("varlat_line_data", done_data, exp_line(32'h0000_1220, 1'b0));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Drop the request in the WAIT of beat 2; a new request raised during the
    // drain must not start until the outstanding word has come back.
    begin_fetch(1);
    lat_tab[2] = 5;
    for (int c = 0; c < 6; c++) step(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    lat_tab[2] = 1;
    while (done_cnt == 0 && cyc < 300) begin
      step(1'b1, 32'h0000_8000, 1'b0, 1'b0);
    end
    chk_int("drop_first_new_strobe", strobe_cyc[3], 12);
    chk_vec("drop_new_strobe_addr", 256'(strobes[3]), 256'h8000);
    chk_int("drop_done_count", done_cnt, 1);
    chk_int("drop_done_cycle", done_cyc, 28);
    chk_int("drop_strobe_count", n_str, 11);
    chk_vec("drop_line_data", done_data, exp_line(32'h0000_8000, 1'b0));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset during the WAIT of beat 4, with that beat's word arriving late.
    begin_fetch(1);
    lat_tab[4] = 3;
    for (int c = 0; c < 10; c++) step(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b1, 32'h0000_1234, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_int("rstmid_done", int'(mmu_l1_done), 0);
    chk_int("rstmid_mem_read", int'(mem_read), 0);
    chk_vec("rstmid_mem_addr", 256'(mem_addr), 256'h0);
    chk_vec("rstmid_read_data", mmu_l1_read_data, 256'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_vec("rstmid_late_rvalid_ignored", mmu_l1_read_data, 256'h0);
    chk_int("rstmid_strobes", n_str, 5);
    chk_int("rstmid_no_done", done_cnt, 0);
    begin_fetch(1);
    while (done_cnt == 0 && cyc < 300) begin
      step(1'b1, 32'h0000_4000, 1'b0, 1'b0);
    end
    chk_int("rstmid_refetch_done_cycle", done_cyc, 17);
    chk_vec("rstmid_refetch_data", done_data, exp_line(32'h0000_4000, 1'b0));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Back-to-back: request stays high through GAP with a new address. GAP
    // ignores it, IDLE accepts it two cycles after done, the strobe follows.
    begin_fetch(1);
    while (done_cnt == 0 && cyc < 300) begin
      step(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    end
    first_done = done_cyc;
    while (done_cnt < 2 && cyc < 300) begin
      step(1'b1, 32'h0000_2000, 1'b0, 1'b0);
    end
    chk_int("b2b_first_done", first_done, 17);
    chk_int("b2b_last_old_strobe", strobe_cyc[7], 15);
    chk_int("b2b_first_new_strobe", strobe_cyc[8], 20);
    chk_vec("b2b_new_strobe_addr", 256'(strobes[8]), 256'h2000);
    chk_int("b2b_done_count", done_cnt, 2);
    chk_int("b2b_second_done", done_cyc, 36);
    chk_vec("b2b_second_data", done_data, exp_line(32'h0000_2000, 1'b0));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    chk_int("no_double_done", dbl_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
